ysyx_25040101_lsu_ctrl: RTL and testbench

//   Multi-cycle load/store unit that replaces the combinational DPI memory access after the ALU.

---
 rtl/ysyx_25040101_lsu_ctrl_if.sv | 38 +++
 rtl/ysyx_25040101_lsu_ctrl.sv | 99 +++++++++
 tb/tb_ysyx_25040101_lsu_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/ysyx_25040101_lsu_ctrl_if.sv
// ysyx_25040101_lsu_ctrl_if: EXU request, WBU response and memory bus signals of the LSU; slave = LSU side, master = EXU/WBU/bus side
interface ysyx_25040101_lsu_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_we_i;
  logic [1:0]            req_size_i;
  logic                  req_sext_i;
  logic [ADDR_W-1:0]     req_addr_i;
  logic [DATA_W-1:0]     req_wdata_i;
  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_W-1:0]     rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  mem_req_valid_o;
  logic                  mem_req_ready_i;
  logic                  mem_we_o;
  logic [ADDR_W-1:0]     mem_addr_o;
  logic [DATA_W-1:0]     mem_wdata_o;
  logic [DATA_W/8-1:0]   mem_wstrb_o;
  logic                  mem_rsp_valid_i;
  logic [DATA_W-1:0]     mem_rsp_rdata_i;
  logic                  mem_rsp_err_i;
  modport slave (
    input  req_valid_i, req_we_i, req_size_i, req_sext_i, req_addr_i, req_wdata_i,
           rsp_ready_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
  modport master (
    output req_valid_i, req_we_i, req_size_i, req_sext_i, req_addr_i, req_wdata_i,
           rsp_ready_i, mem_req_ready_i, mem_rsp_valid_i, mem_rsp_rdata_i, mem_rsp_err_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
           mem_req_valid_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_wstrb_o
  );
endinterface

// File: rtl/ysyx_25040101_lsu_ctrl.sv
// ysyx_25040101_lsu_ctrl: multi-cycle load/store unit; ports clk_i, rst_i (async, active-high) and bus (EXU req / WBU rsp / memory bus, slave modport)
module ysyx_25040101_lsu_ctrl #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 256
) (
  input logic                       clk_i,
  input logic                       rst_i,
  ysyx_25040101_lsu_ctrl_if.slave   bus
);
  localparam int SW = DATA_W / 8;
  localparam int OW = $clog2(SW);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic r_we, r_sext, r_err, r_stale;
  logic [1:0] r_size;
  logic [OW-1:0] r_off;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata, r_rdata;
  logic [SW-1:0] r_wstrb;
  logic [31:0] r_cnt;
  logic [OW-1:0] w_off, w_amask;
  logic [SW-1:0] w_smask;
  logic w_acc, w_bad, w_take, w_to, w_sb;
  logic [DATA_W-1:0] w_field, w_mask, w_ext;
  assign w_off   = bus.req_addr_i[OW-1:0];
  assign w_amask = ~({OW{1'b1}} << bus.req_size_i);
  assign w_smask = ~({SW{1'b1}} << (4'd1 << bus.req_size_i));
  assign w_acc   = r_state == IDLE && bus.req_valid_i;
  assign w_bad   = (bus.req_size_i == 2'd3 && DATA_W != 64) || |(w_off & w_amask);
  // a response while stale is set belongs to a timed-out access and is dropped
  assign w_take  = r_state == WAIT && bus.mem_rsp_valid_i && !r_stale;
  assign w_to    = TIMEOUT != 0 && r_state == WAIT && !w_take && r_cnt == 32'(TIMEOUT - 1);
  assign w_field = bus.mem_rsp_rdata_i >> {r_off, 3'b000};
  // full-width loads give an all-ones mask, so sext has no effect there
  assign w_mask  = ~({DATA_W{1'b1}} << (7'd8 << r_size));
  assign w_sb    = r_size == 2'd0 ? w_field[7] : r_size == 2'd1 ? w_field[15] :
                   r_size == 2'd2 ? w_field[31] : w_field[DATA_W-1];
  assign w_ext   = r_sext && w_sb ? w_field | ~w_mask : w_field & w_mask;
  assign bus.req_ready_o     = r_state == IDLE;
  assign bus.rsp_valid_o     = r_state == RESP;
  assign bus.rsp_rdata_o     = r_rdata;
  assign bus.rsp_err_o       = r_err;
  assign bus.mem_req_valid_o = r_state == REQ;
  assign bus.mem_we_o        = r_we;
  assign bus.mem_addr_o      = r_addr;
  assign bus.mem_wdata_o     = r_wdata;
  assign bus.mem_wstrb_o     = r_wstrb;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = w_acc ? (w_bad ? RESP : REQ) : IDLE;
      REQ:     w_next = bus.mem_req_ready_i ? WAIT : REQ;
      WAIT:    w_next = w_take || w_to ? RESP : WAIT;
      RESP:    w_next = bus.rsp_ready_i ? IDLE : RESP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= IDLE;
    else r_state <= w_next;
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_we    <= 1'b0;
      r_sext  <= 1'b0;
      r_size  <= '0;
      r_off   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_stale <= 1'b0;
    end else begin
      if (w_acc) begin
        r_we    <= bus.req_we_i;
        r_sext  <= bus.req_sext_i;
        r_size  <= bus.req_size_i;
        r_off   <= w_off;
        r_addr  <= {bus.req_addr_i[ADDR_W-1:OW], {OW{1'b0}}};
        r_wdata <= bus.req_wdata_i << {w_off, 3'b000};
        r_wstrb <= bus.req_we_i ? w_smask << w_off : '0;
        r_rdata <= '0;
        r_err   <= w_bad;
      end else if (w_take) begin
        r_rdata <= r_we || bus.mem_rsp_err_i ? '0 : w_ext;
        r_err   <= bus.mem_rsp_err_i;
      end else if (w_to) begin
        r_rdata <= '0;
        r_err   <= 1'b1;
      end
      if (r_state == REQ && bus.mem_req_ready_i) r_cnt <= '0;
      else if (r_state == WAIT) r_cnt <= r_cnt + 32'd1;
      if (w_to) r_stale <= 1'b1;
      else if (bus.mem_rsp_valid_i) r_stale <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ysyx_25040101_lsu_ctrl.sv
// tb_ysyx_25040101_lsu_ctrl: directed and randomized LSU transactions checked against a behavioural model
module tb_ysyx_25040101_lsu_ctrl;
  localparam int TO = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  bit stale = 1'b0;
  ysyx_25040101_lsu_ctrl_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  ysyx_25040101_lsu_ctrl #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ld_model(input logic [31:0] rd, input logic [1:0] sz, input bit sx, input int off);
    int n;
    logic [63:0] m, f;
    n = 8 << sz;
    m = (64'd1 << n) - 64'd1;
    f = ({32'd0, rd} >> (8 * off)) & m;
    if (sx && n < 32 && f[n-1]) f = f | ~m;
    return f[31:0];
  endfunction
  task automatic check_reset_vals();
    check("rst_req_ready", bus.req_ready_o, 1);
    check("rst_rsp_valid", bus.rsp_valid_o, 0);
    check("rst_rsp_rdata", bus.rsp_rdata_o, 0);
    check("rst_rsp_err", bus.rsp_err_o, 0);
    check("rst_mem_valid", bus.mem_req_valid_o, 0);
    check("rst_mem_we", bus.mem_we_o, 0);
    check("rst_mem_addr", bus.mem_addr_o, 0);
    check("rst_mem_wdata", bus.mem_wdata_o, 0);
    check("rst_mem_wstrb", bus.mem_wstrb_o, 0);
  endtask
  task automatic junk();
    bus.mem_rsp_valid_i = 1'b1;
    bus.mem_rsp_rdata_i = $urandom;
    bus.mem_rsp_err_i = 1'b1;
    @(negedge clk);
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_err_i = 1'b0;
    stale = 1'b0;
  endtask
  task automatic txn(input bit we, input logic [1:0] sz, input bit sx, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] rdata, input bit berr,
                     input bit silent, input int rdly, input int lat, input int pdly, input bit do_rst);
    bit bad, exp_e;
    int off, n, c, l, w;
    logic [31:0] exp_d, exp_w;
    logic [3:0] exp_s;
    bad = sz == 2'd3 || (addr & ((32'd1 << sz) - 32'd1)) != 0;
    off = int'(addr[1:0]);
    n = 1 << sz;
    exp_e = bad || silent || berr;
    exp_d = (exp_e || we) ? 32'd0 : ld_model(rdata, sz, sx, off);
    exp_s = we ? 4'(((1 << n) - 1) << off) : 4'd0;
    exp_w = wdata << (8 * off);
    check("idle_ready", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1;
    bus.req_we_i = we;
    bus.req_size_i = sz;
    bus.req_sext_i = sx;
    bus.req_addr_i = addr;
    bus.req_wdata_i = wdata;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    if (!bad) begin
      for (int i = 0; i <= rdly; i++) begin
        check("req_valid", bus.mem_req_valid_o, 1);
        check("req_busy", bus.req_ready_o, 0);
        check("req_addr", bus.mem_addr_o, addr & 32'hFFFF_FFFC);
        check("req_we", bus.mem_we_o, we);
        check("req_wstrb", bus.mem_wstrb_o, exp_s);
        if (we) check("req_wdata", bus.mem_wdata_o, exp_w);
        if (i == rdly) bus.mem_req_ready_i = 1'b1;
        @(negedge clk);
      end
      bus.mem_req_ready_i = 1'b0;
      if (silent) begin
        w = 0;
        while (!bus.rsp_valid_o && w < 20) begin
          @(negedge clk);
          w++;
        end
        check("timeout_cycles", w, TO);
        stale = 1'b1;
      end else begin
        c = 1;
        if (stale) begin
          junk();
          c = 2;
        end
        l = lat < c ? c : lat;
        repeat (l - c) @(negedge clk);
        check("wait_no_rsp", bus.rsp_valid_o, 0);
        check("wait_no_req", bus.mem_req_valid_o, 0);
        if (do_rst) begin
          #2 rst = 1'b1;
          #1 check_reset_vals();
          @(negedge clk);
          rst = 1'b0;
          stale = 1'b0;
          return;
        end
        bus.mem_rsp_valid_i = 1'b1;
        bus.mem_rsp_rdata_i = rdata;
        bus.mem_rsp_err_i = berr;
        @(negedge clk);
        bus.mem_rsp_valid_i = 1'b0;
        bus.mem_rsp_err_i = 1'b0;
      end
    end
    for (int i = 0; i <= pdly; i++) begin
      check("rsp_valid", bus.rsp_valid_o, 1);
      check("rsp_rdata", bus.rsp_rdata_o, exp_d);
      check("rsp_err", bus.rsp_err_o, exp_e);
      check("rsp_busy", bus.req_ready_o, 0);
      check("rsp_no_req", bus.mem_req_valid_o, 0);
      if (i == pdly) bus.rsp_ready_i = 1'b1;
      @(negedge clk);
    end
    bus.rsp_ready_i = 1'b0;
    check("done_valid", bus.rsp_valid_o, 0);
    check("done_ready", bus.req_ready_o, 1);
  endtask
  initial begin
    logic [1:0] sz;
    logic [31:0] a;
    bus.req_valid_i = 1'b0;
    bus.req_we_i = 1'b0;
    bus.req_size_i = '0;
    bus.req_sext_i = 1'b0;
    bus.req_addr_i = '0;
    bus.req_wdata_i = '0;
    bus.rsp_ready_i = 1'b0;
    bus.mem_req_ready_i = 1'b0;
    bus.mem_rsp_valid_i = 1'b0;
    bus.mem_rsp_rdata_i = '0;
    bus.mem_rsp_err_i = 1'b0;
    #2 check_reset_vals();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    txn(0, 2, 0, 32'h8000_0004, 0, 32'hDEAD_BEEF, 0, 0, 0, 3, 0, 0);
    txn(0, 0, 1, 32'h8000_0003, 0, 32'h8012_3456, 0, 0, 1, 1, 1, 0);
    txn(0, 0, 0, 32'h8000_0003, 0, 32'h8012_3456, 0, 0, 0, 2, 0, 0);
    txn(1, 1, 0, 32'h8000_0002, 32'h0000_1234, 0, 0, 0, 0, 1, 0, 0);
    txn(0, 2, 0, 32'h8000_0001, 0, 0, 0, 0, 0, 1, 0, 0);
    txn(0, 2, 0, 32'h8000_0010, 0, 0, 0, 1, 0, 1, 0, 0);
    junk();
    txn(0, 1, 1, 32'h8000_0012, 0, 32'hF00D_CAFE, 0, 0, 0, 1, 0, 0);
    txn(0, 2, 0, 32'h8000_0008, 0, 32'h1111_2222, 0, 1, 0, 1, 0, 0);
    txn(0, 2, 0, 32'h8000_000C, 0, 32'h3333_4444, 0, 0, 0, 3, 0, 0);
    txn(1, 2, 0, 32'h8000_0020, 32'hA5A5_5A5A, 0, 0, 0, 5, 2, 3, 0);
    txn(0, 2, 0, 32'h8000_0024, 0, 32'h1234_5678, 0, 0, 0, 2, 0, 1);
    txn(0, 0, 1, 32'h8000_0025, 0, 32'h0000_FF00, 1, 0, 0, 1, 0, 0);
    for (int k = 0; k < 300; k++) begin
      sz = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 32'd1);
      txn(1'($urandom), sz, 1'($urandom), a, $urandom, $urandom,
          $urandom_range(0, 15) == 0, $urandom_range(0, 15) == 0,
          $urandom_range(0, 3), $urandom_range(1, TO), $urandom_range(0, 3), 1'b0);
      if ($urandom_range(0, 1) == 0) junk();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
